// File: rtl/obi_rr_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : obi_rr_arbiter_if
// Brief    : Controller-side and secondary-side bus signals of the OBI arbiter
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface obi_rr_arbiter_if #(
   parameter int NUM_CTRL = 4
);
   logic [NUM_CTRL-1:0]    ctrl_req_i;
   logic [NUM_CTRL-1:0]    ctrl_gnt_o;
   logic [32*NUM_CTRL-1:0] ctrl_addr_i;
   logic [NUM_CTRL-1:0]    ctrl_we_i;
   logic [4*NUM_CTRL-1:0]  ctrl_be_i;
   logic [32*NUM_CTRL-1:0] ctrl_wdata_i;
   logic [NUM_CTRL-1:0]    ctrl_rvalid_o;
   logic [31:0]            ctrl_rdata_o;

   logic                   secondary_req_o;
   logic                   secondary_gnt_i;
   logic [31:0]            secondary_addr_o;
   logic                   secondary_we_o;
   logic [3:0]             secondary_be_o;
   logic [31:0]            secondary_wdata_o;
   logic                   secondary_rvalid_i;
   logic [31:0]            secondary_rdata_i;

   logic                   err_o;

   // Environment side: drives the controllers and the secondary memory
   modport master (
      output ctrl_req_i, ctrl_addr_i, ctrl_we_i, ctrl_be_i, ctrl_wdata_i,
      output secondary_gnt_i, secondary_rvalid_i, secondary_rdata_i,
      input  ctrl_gnt_o, ctrl_rvalid_o, ctrl_rdata_o,
      input  secondary_req_o, secondary_addr_o, secondary_we_o,
      input  secondary_be_o, secondary_wdata_o, err_o
   );

   // Arbiter side
   modport slave (
      input  ctrl_req_i, ctrl_addr_i, ctrl_we_i, ctrl_be_i, ctrl_wdata_i,
      input  secondary_gnt_i, secondary_rvalid_i, secondary_rdata_i,
      output ctrl_gnt_o, ctrl_rvalid_o, ctrl_rdata_o,
      output secondary_req_o, secondary_addr_o, secondary_we_o,
      output secondary_be_o, secondary_wdata_o, err_o
   );
endinterface

`default_nettype wire

// File: rtl/obi_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : obi_rr_arbiter
// Brief    : N-to-1 round-robin OBI arbiter with in-order response routing
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module obi_rr_arbiter #(
   parameter int NUM_CTRL        = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  wire logic          clk_i,
   input  wire logic          rst_i,
   obi_rr_arbiter_if.slave    bus
);

   localparam int IDX_W = $clog2(NUM_CTRL);
   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = PTR_W + 1;

   logic [IDX_W-1:0] r_last_idx;
   logic [IDX_W-1:0] r_lock_idx;
   logic             r_lock_vld;
   logic [IDX_W-1:0] r_fifo [MAX_OUTSTANDING];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             r_err;

   logic [IDX_W-1:0] w_rr_idx;
   logic [IDX_W-1:0] w_sel;
   logic [IDX_W-1:0] w_head_idx;
   logic             w_lock_hold;
   logic             w_any_req;
   logic             w_full;
   logic             w_empty;
   logic             w_sec_req;
   logic             w_hs;
   logic             w_pop;

   // Lowest offset from last_idx+1 wins, so iterate from the far end down
   always_comb begin : p_rr_search
      logic [IDX_W-1:0] v_idx;
      w_rr_idx = r_last_idx;
      v_idx    = '0;
      for (int i = NUM_CTRL; i >= 1; i--) begin
         v_idx = IDX_W'((int'(r_last_idx) + i) % NUM_CTRL);
         if (bus.ctrl_req_i[v_idx]) begin
            w_rr_idx = v_idx;
         end
      end
   end

   assign w_lock_hold = r_lock_vld && bus.ctrl_req_i[r_lock_idx];
   assign w_sel       = w_lock_hold ? r_lock_idx : w_rr_idx;
   assign w_any_req   = |bus.ctrl_req_i;
   assign w_full      = (r_count == CNT_W'(MAX_OUTSTANDING));
   assign w_empty     = (r_count == '0);
   assign w_sec_req   = w_any_req && !w_full;
   assign w_hs        = w_sec_req && bus.secondary_gnt_i;
   assign w_pop       = bus.secondary_rvalid_i && !w_empty;
   assign w_head_idx  = r_fifo[r_rptr];

   assign bus.secondary_req_o   = w_sec_req;
   assign bus.secondary_addr_o  = bus.ctrl_addr_i[{w_sel, 5'd0} +: 32];
   assign bus.secondary_we_o    = bus.ctrl_we_i[w_sel];
   assign bus.secondary_be_o    = bus.ctrl_be_i[{w_sel, 2'd0} +: 4];
   assign bus.secondary_wdata_o = bus.ctrl_wdata_i[{w_sel, 5'd0} +: 32];
   assign bus.ctrl_gnt_o        = w_hs  ? (NUM_CTRL'(1) << w_sel)      : '0;
   assign bus.ctrl_rvalid_o     = w_pop ? (NUM_CTRL'(1) << w_head_idx) : '0;
   assign bus.ctrl_rdata_o      = bus.secondary_rdata_i;
   assign bus.err_o             = r_err;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_last_idx <= IDX_W'(NUM_CTRL - 1);
         r_lock_idx <= '0;
         r_lock_vld <= 1'b0;
      end else begin
         if (w_hs) begin
            r_last_idx <= w_sel;
         end
         // An offered but unaccepted request pins the selection
         r_lock_vld <= w_sec_req && !bus.secondary_gnt_i;
         r_lock_idx <= w_sel;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_hs) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_hs) - CNT_W'(w_pop);
         if (bus.secondary_rvalid_i && w_empty) begin
            r_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_hs) begin
         r_fifo[r_wptr] <= w_sel;
      end
   end

endmodule

`default_nettype wire

// File: doc/obi_rr_arbiter.md
OBI_RR_ARBITER -- requirements
Module: obi_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_CTRL, default 4, number of controller (primary) ports, range 2..8.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, depth of the response-routing FIFO, power of two, range 2..16.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk_i  input  1  sole clock, all state on rising edge.
REQ-004 rst_i  input  1  asynchronous active-high reset.
REQ-005 ctrl_req_i  input  NUM_CTRL  per-controller request; ctrl_gnt_o  output  NUM_CTRL  per-controller grant.
REQ-006 ctrl_addr_i  input  32*NUM_CTRL; ctrl_we_i  input  NUM_CTRL; ctrl_be_i  input  4*NUM_CTRL; ctrl_wdata_i  input  32*NUM_CTRL; controller k occupies slice k.
REQ-007 ctrl_rvalid_o  output  NUM_CTRL  one-hot response valid; ctrl_rdata_o  output  32  response data broadcast to all controllers.
REQ-008 secondary_req_o  output  1; secondary_gnt_i  input  1; secondary_addr_o  output  32; secondary_we_o  output  1; secondary_be_o  output  4; secondary_wdata_o  output  32.
REQ-009 secondary_rvalid_i  input  1; secondary_rdata_i  input  32.
REQ-010 err_o  output  1  sticky flag: response received with no outstanding transaction.

Function
REQ-011 Selection SHALL be round-robin: search starts at index (last_idx+1) mod NUM_CTRL, picks first asserted ctrl_req_i; last_idx resets to NUM_CTRL-1 (so controller 0 has first priority).
REQ-012 secondary_req_o SHALL be combinational: high when any ctrl_req_i is high and FIFO not full.
REQ-013 secondary_addr_o/we_o/be_o/wdata_o SHALL mux the slice of the selected controller, combinational, zero latency; value when no request is don't-care but SHALL be driven from selected index (no X).
REQ-014 ctrl_gnt_o[sel] SHALL equal secondary_gnt_i AND secondary_req_o; all other grant bits 0; zero-cycle latency.
REQ-015 Handshake = secondary_req_o AND secondary_gnt_i; on handshake last_idx SHALL update to sel at next edge.
REQ-016 Lock: if secondary_req_o high without secondary_gnt_i, selection SHALL be frozen (lock register holds sel) until handshake; higher-priority new requests SHALL NOT preempt.
REQ-017 If locked controller drops ctrl_req_i (protocol violation), lock SHALL clear and re-arbitration occurs same cycle.
REQ-018 FIFO SHALL push sel on every handshake (reads and writes) and pop on secondary_rvalid_i; responses are in order.
REQ-019 ctrl_rvalid_o SHALL be one-hot at FIFO head index when secondary_rvalid_i high, else all 0; combinational, zero latency; ctrl_rdata_o = secondary_rdata_i.
REQ-020 Full: with MAX_OUTSTANDING entries, secondary_req_o SHALL be 0 even if a pop occurs same cycle (no push-through-pop).
REQ-021 Empty: secondary_rvalid_i with empty FIFO SHALL produce no ctrl_rvalid_o, no pointer change, and set err_o until reset.
REQ-022 Simultaneous push and pop when not full SHALL keep count unchanged and preserve order; pointers wrap modulo MAX_OUTSTANDING.
REQ-023 Count SHALL be ceil(log2(MAX_OUTSTANDING))+1 bits, never exceed MAX_OUTSTANDING, never underflow.

Reset
REQ-024 rst_i assertion SHALL immediately clear FIFO (count 0, pointers 0), lock, err_o, set last_idx = NUM_CTRL-1, independent of clk_i.
REQ-025 During reset outputs SHALL be: ctrl_gnt_o 0, ctrl_rvalid_o 0, err_o 0; secondary_req_o follows REQ-012 combinationally (controllers hold req low in reset).
REQ-026 Reset mid-transaction SHALL discard outstanding routing; responses arriving after reset SHALL set err_o.

Verification
REQ-027 All four req high, gnt always 1 -> grants in order 0,1,2,3,0 on consecutive cycles, secondary_addr_o tracks granted slice.
REQ-028 req0 high, gnt low 3 cycles, req1 asserts in cycle 2 -> sel stays 0, addr stable, gnt_o[0] on cycle 4, then controller 1 granted.
REQ-029 MAX_OUTSTANDING=4, gnt=1, no rvalid -> 4 handshakes then secondary_req_o 0; one rvalid -> req reasserts next cycle.
REQ-030 Handshakes from controllers 2,0,3 then three rvalid pulses with data A,B,C -> ctrl_rvalid_o 0b0100,0b0001,0b1000 with rdata A,B,C.
REQ-031 rvalid with empty FIFO -> ctrl_rvalid_o 0, err_o 1 and held; rst_i pulse -> err_o 0.
REQ-032 rst_i asserted with 3 outstanding, between clock edges -> count 0 immediately, priority back to controller 0.
